// File: rtl/axi_chan_pkg.sv
// rtl/axi_chan_pkg.sv - shared AXI channel payload types and sizing helpers
//
// Purpose: packed AXI channel structs used by wrappers to form opaque buffer
// payloads (PAYLOAD_WIDTH = $bits(axi_x_t)), plus the count-port sizing
// function used by axi_chan_buf.
// Ports: none (package).

package axi_chan_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Address channel (shared by AR and AW).
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        axi_burst_e                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
    } axi_a_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
    } axi_w_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        axi_resp_e               resp;
    } axi_b_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        axi_resp_e                 resp;
        logic                      last;
    } axi_r_t;

    // Width of the occupancy port: one extra bit so a full buffer (count =
    // DEPTH) is representable; a bypass instance still gets a 1-bit port.
    function automatic int clog2_cnt(input int depth);
        return (depth == 0) ? 1 : $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axi_chan_buf_mem.sv
// rtl/axi_chan_buf_mem.sv - DEPTH x PAYLOAD_WIDTH register file for axi_chan_buf
//
// Purpose: storage for the elastic buffer; one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)

module axi_chan_buf_mem #(
    parameter int PAYLOAD_WIDTH = 64,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [PAYLOAD_WIDTH-1:0]   wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [PAYLOAD_WIDTH-1:0]   rdata
);

    logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_chan_buf.sv
// rtl/axi_chan_buf.sv - elastic valid/ready buffer for one AXI or APB-style channel
//
// Purpose: decouples ready timing between a channel source and destination.
// DEPTH = 0 is a pure combinational pass-through; DEPTH >= 2 (power of two) is
// a pointer-based FIFO whose handshake outputs depend on flops only.
// Ports:
//   clk, rst_n          - channel clock, asynchronous active-low reset
//   flush               - synchronous discard of all held entries
//   s_valid/s_ready     - upstream handshake, s_payload upstream data
//   m_valid/m_ready     - downstream handshake, m_payload downstream data
//   count               - entries currently held (0..DEPTH)
//   afull               - count >= AFULL_LVL

module axi_chan_buf
    import axi_chan_pkg::*;
#(
    parameter int PAYLOAD_WIDTH = 64,
    parameter int DEPTH         = 4,
    parameter int AFULL_LVL     = DEPTH - 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [PAYLOAD_WIDTH-1:0]        s_payload,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [PAYLOAD_WIDTH-1:0]        m_payload,
    output logic [clog2_cnt(DEPTH)-1:0]     count,
    output logic                            afull
);

    generate
        if (DEPTH == 0) begin : g_bypass

            // Stateless wire-through; clock, reset and flush have no effect.
            assign m_valid   = s_valid;
            assign s_ready   = m_ready;
            assign m_payload = s_payload;
            assign count     = '0;
            assign afull     = 1'b0;

            logic unused_bypass;
            assign unused_bypass = &{1'b0, clk, rst_n, flush};

        end else begin : g_buffer

            localparam int AW = $clog2(DEPTH);
            localparam int PW = AW + 1;

            // Out-of-range thresholds saturate: above DEPTH never asserts,
            // at or below zero always asserts.
            localparam int AFULL_CLAMP = (AFULL_LVL < 0)     ? 0 :
                                         (AFULL_LVL > DEPTH) ? DEPTH + 1 :
                                                               AFULL_LVL;
            localparam logic [PW-1:0] AFULL_THR = PW'(AFULL_CLAMP);

            logic [PW-1:0] wr_ptr;
            logic [PW-1:0] rd_ptr;
            logic          empty;
            logic          full;
            logic          push;
            logic          pop;

            // Wrap bit distinguishes full from empty when the index bits match.
            assign empty = (wr_ptr == rd_ptr);
            assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                           (wr_ptr[AW] != rd_ptr[AW]);

            assign s_ready = !full;
            assign m_valid = !empty;

            assign push = s_valid && !full;
            assign pop  = !empty && m_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
            end

            // Pointer-width subtraction wraps modulo 2*DEPTH, giving 0..DEPTH.
            assign count = wr_ptr - rd_ptr;
            assign afull = (count >= AFULL_THR);

            axi_chan_buf_mem #(
                .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
                .DEPTH         (DEPTH)
            ) u_mem (
                .clk   (clk),
                .we    (push && !flush),
                .waddr (wr_ptr[AW-1:0]),
                .wdata (s_payload),
                .raddr (rd_ptr[AW-1:0]),
                .rdata (m_payload)
            );

        end
    endgenerate

endmodule

// File: tb/tb_axi_chan_buf.sv
// tb/tb_axi_chan_buf.sv - directed self-checking bench for axi_chan_buf

module tb_axi_chan_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       s4_valid = 1'b0, s4_ready, m4_valid, m4_ready = 1'b0, afull4;
    logic [7:0] s4_payload = '0, m4_payload;
    logic [2:0] cnt4;

    // DEPTH=0 bypass instance
    logic       s0_valid = 1'b0, s0_ready, m0_valid, m0_ready = 1'b0, afull0;
    logic [7:0] s0_payload = '0, m0_payload;
    logic [0:0] cnt0;

    // DEPTH=2 instance
    logic       s2_valid = 1'b0, s2_ready, m2_valid, m2_ready = 1'b0, afull2;
    logic [7:0] s2_payload = '0, m2_payload;
    logic [1:0] cnt2;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    axi_chan_buf #(.PAYLOAD_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s4_valid), .s_ready(s4_ready), .s_payload(s4_payload),
        .m_valid(m4_valid), .m_ready(m4_ready), .m_payload(m4_payload),
        .count(cnt4), .afull(afull4)
    );

    axi_chan_buf #(.PAYLOAD_WIDTH(8), .DEPTH(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s0_valid), .s_ready(s0_ready), .s_payload(s0_payload),
        .m_valid(m0_valid), .m_ready(m0_ready), .m_payload(m0_payload),
        .count(cnt0), .afull(afull0)
    );

    axi_chan_buf #(.PAYLOAD_WIDTH(8), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s2_valid), .s_ready(s2_ready), .s_payload(s2_payload),
        .m_valid(m2_valid), .m_ready(m2_ready), .m_payload(m2_payload),
        .count(cnt2), .afull(afull2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_cnt++; if (m4_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m4_valid); else pass_cnt++;
        chk_cnt++; if (s4_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s4_ready); else pass_cnt++;
        chk_cnt++; if (cnt4 !== 3'd0) $display("FAIL reset_count got %0d want 0", cnt4); else pass_cnt++;
        chk_cnt++; if (afull4 !== 1'b0) $display("FAIL reset_afull got %b want 0", afull4); else pass_cnt++;
        chk_cnt++; if (m2_valid !== 1'b0 || s2_ready !== 1'b1) $display("FAIL reset_d2 got v=%b r=%b want v=0 r=1", m2_valid, s2_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill();
        m4_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s4_valid   = 1'b1;
            s4_payload = 8'(160 + i);
            step();
            chk_cnt++; if (cnt4 !== 3'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, cnt4, i + 1); else pass_cnt++;
            chk_cnt++; if (afull4 !== (i >= 2)) $display("FAIL fill_afull[%0d] got %b want %b", i, afull4, (i >= 2)); else pass_cnt++;
            chk_cnt++; if (s4_ready !== (i < 3)) $display("FAIL fill_s_ready[%0d] got %b want %b", i, s4_ready, (i < 3)); else pass_cnt++;
        end
        // Fifth beat offered while full: must be held off.
        s4_payload = 8'hA4;
        step();
        chk_cnt++; if (cnt4 !== 3'd4) $display("FAIL fill_hold_count got %0d want 4", cnt4); else pass_cnt++;
        chk_cnt++; if (s4_ready !== 1'b0) $display("FAIL fill_hold_s_ready got %b want 0", s4_ready); else pass_cnt++;
        chk_cnt++; if (m4_valid !== 1'b1 || m4_payload !== 8'hA0) $display("FAIL fill_head got v=%b p=%h want v=1 p=a0", m4_valid, m4_payload); else pass_cnt++;
    endtask

    task automatic test_drain_full();
        logic [7:0] exp;
        // Full, A4 still offered; pop happens, push refused.
        m4_ready = 1'b1;
        step();
        chk_cnt++; if (cnt4 !== 3'd3) $display("FAIL full_pop_count got %0d want 3", cnt4); else pass_cnt++;
        chk_cnt++; if (s4_ready !== 1'b1) $display("FAIL full_pop_s_ready got %b want 1", s4_ready); else pass_cnt++;
        chk_cnt++; if (m4_payload !== 8'hA1) $display("FAIL full_pop_head got %h want a1", m4_payload); else pass_cnt++;
        m4_ready = 1'b0;
        step();
        s4_valid = 1'b0;
        chk_cnt++; if (cnt4 !== 3'd4) $display("FAIL full_repush_count got %0d want 4", cnt4); else pass_cnt++;
        m4_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(160 + i);
            chk_cnt++; if (m4_valid !== 1'b1 || m4_payload !== exp) $display("FAIL drain[%0d] got v=%b p=%h want v=1 p=%h", i, m4_valid, m4_payload, exp); else pass_cnt++;
            step();
        end
        chk_cnt++; if (m4_valid !== 1'b0 || cnt4 !== 3'd0) $display("FAIL drain_empty got v=%b cnt=%0d want v=0 cnt=0", m4_valid, cnt4); else pass_cnt++;
        m4_ready = 1'b0;
    endtask

    task automatic test_stream();
        m4_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            s4_valid   = (c < 20);
            s4_payload = 8'(c);
            if (c == 0) begin
                chk_cnt++; if (m4_valid !== 1'b0) $display("FAIL stream_no_fallthrough got %b want 0", m4_valid); else pass_cnt++;
            end else begin
                chk_cnt++; if (m4_valid !== 1'b1 || m4_payload !== 8'(c - 1)) $display("FAIL stream_out[%0d] got v=%b p=%h want v=1 p=%h", c, m4_valid, m4_payload, 8'(c - 1)); else pass_cnt++;
                chk_cnt++; if (cnt4 !== 3'd1) $display("FAIL stream_count[%0d] got %0d want 1", c, cnt4); else pass_cnt++;
            end
            step();
        end
        chk_cnt++; if (m4_valid !== 1'b0 || cnt4 !== 3'd0) $display("FAIL stream_end got v=%b cnt=%0d want v=0 cnt=0", m4_valid, cnt4); else pass_cnt++;
        s4_valid = 1'b0;
        m4_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m4_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s4_valid   = 1'b1;
            s4_payload = 8'(8'h31 + i);
            step();
        end
        s4_valid = 1'b0;
        chk_cnt++; if (cnt4 !== 3'd3) $display("FAIL midrst_pre_count got %0d want 3", cnt4); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (m4_valid !== 1'b0) $display("FAIL midrst_m_valid got %b want 0", m4_valid); else pass_cnt++;
        chk_cnt++; if (s4_ready !== 1'b1) $display("FAIL midrst_s_ready got %b want 1", s4_ready); else pass_cnt++;
        chk_cnt++; if (cnt4 !== 3'd0) $display("FAIL midrst_count got %0d want 0", cnt4); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_flush();
        m4_ready = 1'b0;
        s4_valid = 1'b1; s4_payload = 8'h11; step();
        s4_payload = 8'h22; step();
        s4_valid = 1'b0;
        chk_cnt++; if (cnt4 !== 3'd2) $display("FAIL flush_pre_count got %0d want 2", cnt4); else pass_cnt++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_cnt++; if (cnt4 !== 3'd0 || m4_valid !== 1'b0 || s4_ready !== 1'b1) $display("FAIL flush_state got cnt=%0d v=%b r=%b want cnt=0 v=0 r=1", cnt4, m4_valid, s4_ready); else pass_cnt++;
        s4_valid = 1'b1; s4_payload = 8'h55; step();
        s4_valid = 1'b0;
        chk_cnt++; if (m4_valid !== 1'b1 || m4_payload !== 8'h55 || cnt4 !== 3'd1) $display("FAIL flush_repush got v=%b p=%h cnt=%0d want v=1 p=55 cnt=1", m4_valid, m4_payload, cnt4); else pass_cnt++;
        m4_ready = 1'b1;
        step();
        chk_cnt++; if (m4_valid !== 1'b0 || cnt4 !== 3'd0) $display("FAIL flush_alone got v=%b cnt=%0d want v=0 cnt=0", m4_valid, cnt4); else pass_cnt++;
        m4_ready = 1'b0;
    endtask

    task automatic test_bypass();
        logic       v, r;
        logic [7:0] p;
        for (int i = 0; i < 4; i++) begin
            v = (i < 2);
            r = (i % 2 == 0);
            p = 8'h3C ^ 8'(i * 17);
            s0_valid = v; m0_ready = r; s0_payload = p;
            #1;
            chk_cnt++; if (m0_valid !== v || s0_ready !== r || m0_payload !== p) $display("FAIL bypass[%0d] got v=%b r=%b p=%h want v=%b r=%b p=%h", i, m0_valid, s0_ready, m0_payload, v, r, p); else pass_cnt++;
            chk_cnt++; if (cnt0 !== 1'b0 || afull0 !== 1'b0) $display("FAIL bypass_status[%0d] got cnt=%0d af=%b want 0 0", i, cnt0, afull0); else pass_cnt++;
        end
        step();
    endtask

    task automatic test_backpressure();
        int         tx = 0;
        int         rx = 0;
        bit         stall_prev = 1'b0;
        bit         push;
        logic [7:0] held = '0;
        s2_valid = 1'b0;
        for (int cyc = 0; cyc < 2000 && rx < 40; cyc++) begin
            if (!s2_valid && tx < 40 && $urandom_range(0, 3) != 0) begin
                s2_valid   = 1'b1;
                s2_payload = 8'(tx);
            end
            m2_ready = 1'($urandom_range(0, 1));
            #1;
            if (stall_prev) begin
                chk_cnt++; if (m2_valid !== 1'b1 || m2_payload !== held) $display("FAIL bp_stable cyc %0d got v=%b p=%h want v=1 p=%h", cyc, m2_valid, m2_payload, held); else pass_cnt++;
            end
            if (m2_valid && m2_ready) begin
                chk_cnt++; if (m2_payload !== 8'(rx)) $display("FAIL bp_order got %h want %h", m2_payload, 8'(rx)); else pass_cnt++;
                rx++;
            end
            stall_prev = m2_valid && !m2_ready;
            held       = m2_payload;
            push       = s2_valid && s2_ready;
            step();
            if (push) begin
                tx++;
                s2_valid = 1'b0;
            end
        end
        s2_valid = 1'b0;
        m2_ready = 1'b0;
        chk_cnt++; if (rx != 40) $display("FAIL bp_received got %0d want 40", rx); else pass_cnt++;
        chk_cnt++; if (cnt2 !== 2'd0) $display("FAIL bp_final_count got %0d want 0", cnt2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_full();
        test_stream();
        test_reset_mid();
        test_flush();
        test_bypass();
        test_backpressure();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
